// File: rtl/keypad_pkg.sv
// Shared constants and bit-vector helpers for the matrix keypad scanner.
// Helpers work on a 64-bit vector so any ROWS*COLS up to 8x8 can zero-extend into them.
package keypad_pkg;

  localparam int ROWS_DEF          = 4;
  localparam int COLS_DEF          = 4;
  localparam int SCAN_DIV_DEF      = 12000;
  localparam int STABLE_FRAMES_DEF = 20;
  localparam int MAX_KEYS          = 64;

  function automatic int code_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_KEYS-1:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [5:0] onehot_index(input logic [MAX_KEYS-1:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 6'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous level inputs.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Active row-scanning keypad reader: frame-stability debounce and single-key press
// events delivered over a valid/ready handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = ROWS_DEF,
  parameter int COLS          = COLS_DEF,
  parameter int SCAN_DIV      = SCAN_DIV_DEF,
  parameter int STABLE_FRAMES = STABLE_FRAMES_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COLS-1:0]                i_col_n,
  output logic [ROWS-1:0]                o_row_n,
  output logic                           o_key_valid,
  input  logic                           i_key_ready,
  output logic [code_w(ROWS, COLS)-1:0]  o_key_code,
  output logic                           o_key_held,
  output logic                           o_key_multi,
  output logic                           o_overflow
);

  localparam int N      = ROWS * COLS;
  localparam int CODE_W = code_w(ROWS, COLS);
  localparam int DW     = $clog2(SCAN_DIV);
  localparam int RW     = $clog2(ROWS);
  localparam int SW     = $clog2(STABLE_FRAMES + 1);

  logic [COLS-1:0]   w_col_sync;
  logic [DW-1:0]     r_dwell;
  logic [RW-1:0]     r_row;
  logic [ROWS-1:0]   r_row_n;
  logic [N-1:0]      r_snapshot;
  logic [N-1:0]      r_prev;
  logic [N-1:0]      r_accepted;
  logic [SW-1:0]     r_stable;
  logic              r_key_valid;
  logic [CODE_W-1:0] r_key_code;
  logic              r_overflow;

  logic [N-1:0]      w_snap_next;
  logic              w_sample;
  logic              w_frame_end;
  logic              w_accept;
  logic              w_event;
  logic [6:0]        w_prev_pop;
  logic [6:0]        w_acc_pop;
  logic [5:0]        w_prev_idx;

  sync_2ff #(
    .W       (COLS),
    .RST_VAL ({COLS{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_col_n),
    .o_q (w_col_sync)
  );

  assign w_sample    = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_frame_end = w_sample && (r_row == RW'(ROWS - 1));

  // The frame-end compare must already see the last row's fresh sample.
  always_comb begin
    w_snap_next = r_snapshot;
    w_snap_next[r_row*COLS +: COLS] = ~w_col_sync;
  end

  assign w_prev_pop = popcount(64'(r_prev));
  assign w_acc_pop  = popcount(64'(r_accepted));
  assign w_prev_idx = onehot_index(64'(r_prev));

  assign w_accept = (r_stable == SW'(STABLE_FRAMES)) && (r_prev != r_accepted);
  assign w_event  = w_accept && (r_accepted == {N{1'b0}}) && (w_prev_pop == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= {DW{1'b0}};
      r_row   <= {RW{1'b0}};
      r_row_n <= {{(ROWS-1){1'b1}}, 1'b0};
    end else if (w_sample) begin
      r_dwell <= {DW{1'b0}};
      r_row_n <= {r_row_n[ROWS-2:0], r_row_n[ROWS-1]};
      if (r_row == RW'(ROWS - 1)) begin
        r_row <= {RW{1'b0}};
      end else begin
        r_row <= r_row + RW'(1);
      end
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snapshot <= {N{1'b0}};
      r_prev     <= {N{1'b0}};
      r_stable   <= {SW{1'b0}};
      r_accepted <= {N{1'b0}};
    end else begin
      if (w_sample) begin
        r_snapshot <= w_snap_next;
      end
      if (w_frame_end) begin
        r_prev <= w_snap_next;
        if (w_snap_next != r_prev) begin
          r_stable <= SW'(1);
        end else if (r_stable != SW'(STABLE_FRAMES)) begin
          r_stable <= r_stable + SW'(1);
        end
      end
      if (w_accept) begin
        r_accepted <= r_prev;
      end
    end
  end

  // A new event may replace one being consumed this cycle; otherwise it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= {CODE_W{1'b0}};
      r_overflow  <= 1'b0;
    end else if (w_event) begin
      if (!r_key_valid || i_key_ready) begin
        r_key_valid <= 1'b1;
        r_key_code  <= w_prev_idx[CODE_W-1:0];
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_key_valid && i_key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  assign o_row_n     = r_row_n;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_overflow  = r_overflow;
  assign o_key_held  = (w_acc_pop == 7'd1);
  assign o_key_multi = (w_acc_pop >= 7'd2);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_held;
  logic        key_multi;
  logic        overflow;
  logic [15:0] pressed;

  int checks;
  int failures;
  int cyc;
  int ev_cnt;
  logic [3:0] last_code;

  keypad_scanner #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (8),
    .STABLE_FRAMES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_col_n     (col_n),
    .o_row_n     (row_n),
    .o_key_valid (key_valid),
    .i_key_ready (key_ready),
    .o_key_code  (key_code),
    .o_key_held  (key_held),
    .o_key_multi (key_multi),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key connects its row line to its column line.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  typedef struct {
    int         cyc;
    logic [3:0] row_n;
  } idle_t;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          exp_ev;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic        exp_multi;
  } vec_t;

  idle_t idle_tbl[9];
  vec_t  vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; a handshake visible now completes at the coming edge.
  task automatic step();
    if (!rst && key_valid && key_ready) begin
      ev_cnt++;
      last_code = key_code;
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row_n"}, 32'(row_n), 32'h0000_000e);
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_code"}, 32'(key_code), 32'd0);
    chk({tag, "_held"}, 32'(key_held), 32'd0);
    chk({tag, "_multi"}, 32'(key_multi), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int first;
    int ev0;
    checks = 0; failures = 0; cyc = 0; ev_cnt = 0; last_code = 4'd0;
    rst = 1'b1; key_ready = 1'b1; pressed = 16'h0000;

    idle_tbl[0] = '{0, 4'b1110};  idle_tbl[1] = '{7, 4'b1110};
    idle_tbl[2] = '{8, 4'b1101};  idle_tbl[3] = '{15, 4'b1101};
    idle_tbl[4] = '{16, 4'b1011}; idle_tbl[5] = '{24, 4'b0111};
    idle_tbl[6] = '{31, 4'b0111}; idle_tbl[7] = '{32, 4'b1110};
    idle_tbl[8] = '{40, 4'b1101};

    vt[0] = '{16'h0200, 5, 1, 4'd9,  1'b1, 1'b0};
    vt[1] = '{16'h0000, 5, 0, 4'd0,  1'b0, 1'b0};
    vt[2] = '{16'h8001, 5, 0, 4'd0,  1'b0, 1'b1};
    vt[3] = '{16'h0000, 5, 0, 4'd0,  1'b0, 1'b0};
    vt[4] = '{16'h8000, 5, 1, 4'd15, 1'b1, 1'b0};
    vt[5] = '{16'h8001, 5, 0, 4'd0,  1'b0, 1'b1};
    vt[6] = '{16'h8000, 5, 0, 4'd0,  1'b1, 1'b0};
    vt[7] = '{16'h0000, 5, 0, 4'd0,  1'b0, 1'b0};
    vt[8] = '{16'h0020, 5, 1, 4'd5,  1'b1, 1'b0};
    vt[9] = '{16'h0000, 5, 0, 4'd0,  1'b0, 1'b0};

    // Reset values and idle row rotation.
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("rst");
    do_reset();
    for (int i = 0; i < 9; i++) begin
      while (cyc < idle_tbl[i].cyc) step();
      chk($sformatf("idle_row_n_c%0d", idle_tbl[i].cyc), 32'(row_n), 32'(idle_tbl[i].row_n));
    end
    run(100);
    chk("idle_events", 32'(ev_cnt), 32'd0);
    chk("idle_valid", 32'(key_valid), 32'd0);

    // Key (row 2, col 1) held from reset release: valid after 3 frames + 1 cycle.
    pressed = 16'h0200;
    ev0 = ev_cnt;
    do_reset();
    first = -1;
    while (first < 0 && cyc < 300) begin
      step();
      if (key_valid) first = cyc;
    end
    chk("press_latency", 32'(first), 32'd97);
    chk("press_code", 32'(key_code), 32'd9);
    step();
    chk("press_valid_clear", 32'(key_valid), 32'd0);
    run(64);
    chk("press_held", 32'(key_held), 32'd1);
    chk("press_events", 32'(ev_cnt - ev0), 32'd1);

    // Bounce hitting row-2 sample in frames 0 and 2; frames 1 and 3 bounce elsewhere.
    pressed = 16'h0000;
    do_reset();
    ev0 = ev_cnt;
    first = -1;
    for (int c = 0; c < 320; c++) begin
      int f;
      int ph;
      logic bounce;
      f = cyc / 32;
      ph = cyc % 32;
      bounce = 1'b0;
      if (f < 4) begin
        if (f % 2 == 0) bounce = (ph >= 18 && ph <= 22);
        else            bounce = (ph >= 2 && ph <= 6);
      end
      pressed = bounce ? 16'h0000 : 16'h0200;
      step();
      if (key_valid && first < 0) first = cyc;
    end
    chk("bounce_latency", 32'(first), 32'd193);
    chk("bounce_events", 32'(ev_cnt - ev0), 32'd1);
    chk("bounce_code", 32'(last_code), 32'd9);

    // Table of steady key patterns with ready held high.
    pressed = 16'h0000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ev0 = ev_cnt;
      pressed = vt[i].mask;
      run(vt[i].frames * 32);
      chk($sformatf("vec%0d_events", i), 32'(ev_cnt - ev0), 32'(vt[i].exp_ev));
      if (vt[i].exp_ev == 1) chk($sformatf("vec%0d_code", i), 32'(last_code), 32'(vt[i].exp_code));
      chk($sformatf("vec%0d_held", i), 32'(key_held), 32'(vt[i].exp_held));
      chk($sformatf("vec%0d_multi", i), 32'(key_multi), 32'(vt[i].exp_multi));
    end

    // Back-pressure: press 3, release, press 7 with ready low.
    key_ready = 1'b0;
    pressed = 16'h0000;
    do_reset();
    ev0 = ev_cnt;
    pressed = 16'h0008;
    run(160);
    chk("bp_valid1", 32'(key_valid), 32'd1);
    chk("bp_code1", 32'(key_code), 32'd3);
    chk("bp_ovf1", 32'(overflow), 32'd0);
    pressed = 16'h0000;
    run(160);
    chk("bp_ovf_release", 32'(overflow), 32'd0);
    pressed = 16'h0080;
    run(160);
    chk("bp_valid2", 32'(key_valid), 32'd1);
    chk("bp_code2", 32'(key_code), 32'd3);
    chk("bp_ovf2", 32'(overflow), 32'd1);
    key_ready = 1'b1;
    step();
    chk("bp_valid_clear", 32'(key_valid), 32'd0);
    chk("bp_events", 32'(ev_cnt - ev0), 32'd1);
    chk("bp_code_out", 32'(last_code), 32'd3);

    // Pending event, then reset in the middle of row 2's dwell.
    key_ready = 1'b0;
    pressed = 16'h0000;
    run(160);
    pressed = 16'h1000;
    run(160);
    chk("mid_pend_valid", 32'(key_valid), 32'd1);
    chk("mid_pend_code", 32'(key_code), 32'd12);
    chk("mid_pend_ovf", 32'(overflow), 32'd1);
    first = 0;
    while (row_n != 4'b1011 && first < 200) begin
      step();
      first++;
    end
    chk("mid_find_row2", 32'(row_n), 32'h0000_000b);
    run(3);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    pressed = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
    chk("mid_resume_row0", 32'(row_n), 32'h0000_000e);
    run(8);
    chk("mid_resume_row1", 32'(row_n), 32'h0000_000d);
    run(160);
    chk("mid_after_valid", 32'(key_valid), 32'd0);
    chk("mid_after_ovf", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
